nv_nvdla_csb_slv_fwd: RTL and testbench

- CSB request forwarder sitting directly upstream of a single CSB register slave such as the config ROM.
- Accepts 63-bit CSB requests from the CSB master with a valid/ready handshake and range-checks the address.
- Forwards in-range requests to the slave and returns slave responses to the master.
- Synthesizes error responses for out-of-range accesses and for slave timeouts, so a hung or absent slave never stalls the CSB.

---
 rtl/nv_nvdla_csb_pkg.sv | 42 ++++
 rtl/nv_nvdla_csb_slv_fwd.sv | 121 ++++++++++++
 tb/tb_nv_nvdla_csb_slv_fwd.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nv_nvdla_csb_pkg.sv
// Shared CSB definitions: request/response packing, widths and forwarder FSM states.
// Request: [21:0] addr, [53:22] wdat, [54] write, [55] nposted, [56] srcpriv, [60:57] wrbe, [62:61] level.
package nv_nvdla_csb_pkg;

    localparam int CSB_REQ_W        = 63;
    localparam int CSB_RESP_W       = 34;

    localparam int REQ_ADDR_LSB     = 0;
    localparam int REQ_ADDR_W       = 22;
    localparam int REQ_WDAT_LSB     = 22;
    localparam int REQ_WDAT_W       = 32;
    localparam int REQ_WRITE_BIT    = 54;
    localparam int REQ_NPOSTED_BIT  = 55;
    localparam int REQ_SRCPRIV_BIT  = 56;
    localparam int REQ_WRBE_LSB     = 57;
    localparam int REQ_WRBE_W       = 4;
    localparam int REQ_LEVEL_LSB    = 61;
    localparam int REQ_LEVEL_W      = 2;

    localparam int RESP_DATA_W      = 32;
    localparam int RESP_ERR_BIT     = 32;
    localparam int RESP_TYPE_BIT    = 33;

    localparam int CNT_W            = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } csb_fwd_state_e;

    // Synthesized error response: zero data, error flag set, type follows the request.
    function automatic logic [CSB_RESP_W-1:0] csb_err_resp(input logic is_write);
        logic [CSB_RESP_W-1:0] v;
        v                = '0;
        v[RESP_ERR_BIT]  = 1'b1;
        v[RESP_TYPE_BIT] = is_write;
        return v;
    endfunction

endpackage

// File: rtl/nv_nvdla_csb_slv_fwd.sv
// CSB forwarder in front of a single register slave: range check, single outstanding
// transaction, and synthesized error responses for out-of-range accesses and slave timeouts.
module nv_nvdla_csb_slv_fwd
    import nv_nvdla_csb_pkg::*;
#(
    parameter logic [21:0] ADDR_BASE      = 22'h000000,
    parameter logic [21:0] ADDR_MASK      = 22'h3FFC00,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  csb_req_pvld,
    output logic                  csb_req_prdy,
    input  logic [CSB_REQ_W-1:0]  csb_req_pd,
    output logic                  slv_req_pvld,
    input  logic                  slv_req_prdy,
    output logic [CSB_REQ_W-1:0]  slv_req_pd,
    input  logic                  slv_resp_valid,
    input  logic [CSB_RESP_W-1:0] slv_resp_pd,
    output logic                  csb_resp_valid,
    output logic [CSB_RESP_W-1:0] csb_resp_pd,
    output logic                  stale_resp
);

    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    csb_fwd_state_e        r_state;
    csb_fwd_state_e        w_next;
    logic [CSB_REQ_W-1:0]  r_req;
    logic [CSB_RESP_W-1:0] r_resp_pd;
    logic [CSB_RESP_W-1:0] w_resp_pd;
    logic                  w_resp_ld;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_prdy;
    logic                  r_stale;

    logic w_accept;
    logic w_in_range;
    logic w_in_resp_req;
    logic w_hold_resp_req;

    assign w_accept        = csb_req_pvld & r_prdy;
    assign w_in_range      = ((csb_req_pd[REQ_ADDR_LSB +: REQ_ADDR_W] & ADDR_MASK) == ADDR_BASE);
    assign w_in_resp_req   = ~csb_req_pd[REQ_WRITE_BIT] | csb_req_pd[REQ_NPOSTED_BIT];
    assign w_hold_resp_req = ~r_req[REQ_WRITE_BIT] | r_req[REQ_NPOSTED_BIT];

    always_comb begin
        w_next    = r_state;
        w_resp_ld = 1'b0;
        w_resp_pd = r_resp_pd;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_in_range) begin
                        w_next = ST_ISSUE;
                    end else if (w_in_resp_req) begin
                        w_next    = ST_RESP;
                        w_resp_ld = 1'b1;
                        w_resp_pd = csb_err_resp(csb_req_pd[REQ_WRITE_BIT]);
                    end
                    // out-of-range posted writes are silently dropped
                end
            end
            ST_ISSUE: begin
                if (slv_req_prdy) begin
                    w_next = w_hold_resp_req ? ST_WAIT : ST_IDLE;
                end
            end
            ST_WAIT: begin
                // a real response beats an expiry landing on the same cycle
                if (slv_resp_valid) begin
                    w_next    = ST_RESP;
                    w_resp_ld = 1'b1;
                    w_resp_pd = slv_resp_pd;
                end else if (r_cnt == TO_LAST) begin
                    w_next    = ST_RESP;
                    w_resp_ld = 1'b1;
                    w_resp_pd = csb_err_resp(r_req[REQ_WRITE_BIT]);
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_state   <= ST_IDLE;
            r_req     <= '0;
            r_resp_pd <= '0;
            r_cnt     <= '0;
            r_prdy    <= 1'b0;
            r_stale   <= 1'b0;
        end else begin
            r_state <= w_next;
            // registered ready keeps it low during reset; equals (state==IDLE) otherwise
            r_prdy  <= (w_next == ST_IDLE);
            r_stale <= slv_resp_valid & (r_state != ST_WAIT);
            if (w_accept) begin
                r_req <= csb_req_pd;
            end
            if (w_resp_ld) begin
                r_resp_pd <= w_resp_pd;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT) && (r_cnt != TO_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign csb_req_prdy   = r_prdy;
    assign slv_req_pvld   = (r_state == ST_ISSUE);
    assign slv_req_pd     = r_req;
    assign csb_resp_valid = (r_state == ST_RESP);
    assign csb_resp_pd    = r_resp_pd;
    assign stale_resp     = r_stale;

endmodule

// File: tb/tb_nv_nvdla_csb_slv_fwd.sv
// Scoreboard bench for nv_nvdla_csb_slv_fwd: the driver pushes expected slave requests and
// master responses; an independent monitor pops and compares whenever the DUT presents them.
module tb_nv_nvdla_csb_slv_fwd;
    import nv_nvdla_csb_pkg::*;

    localparam int          TO   = 8;
    localparam logic [21:0] BASE = 22'h000000;
    localparam logic [21:0] MASK = 22'h3FFC00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csb_req_pvld = 1'b0;
    logic        csb_req_prdy;
    logic [62:0] csb_req_pd = '0;
    logic        slv_req_pvld;
    logic        slv_req_prdy = 1'b0;
    logic [62:0] slv_req_pd;
    logic        slv_resp_valid = 1'b0;
    logic [33:0] slv_resp_pd = '0;
    logic        csb_resp_valid;
    logic [33:0] csb_resp_pd;
    logic        stale_resp;

    nv_nvdla_csb_slv_fwd #(
        .ADDR_BASE(BASE), .ADDR_MASK(MASK), .TIMEOUT_CYCLES(TO)
    ) dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .csb_req_pvld(csb_req_pvld), .csb_req_prdy(csb_req_prdy), .csb_req_pd(csb_req_pd),
        .slv_req_pvld(slv_req_pvld), .slv_req_prdy(slv_req_prdy), .slv_req_pd(slv_req_pd),
        .slv_resp_valid(slv_resp_valid), .slv_resp_pd(slv_resp_pd),
        .csb_resp_valid(csb_resp_valid), .csb_resp_pd(csb_resp_pd), .stale_resp(stale_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int acc_cyc = 0;
    int stale_seen = 0;
    int exp_stale = 0;

    logic [62:0] exp_slv_q[$];
    logic [33:0] exp_resp_q[$];
    int          exp_lat_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [62:0] mk(input logic [21:0] addr, input logic [31:0] wdat,
                                       input logic wr, input logic np, input logic [6:0] misc);
        return {misc, np, wr, wdat, addr};
    endfunction

    // Monitor: all scoreboard pops happen here.
    logic        prev_pvld = 1'b0;
    logic        prev_prdy = 1'b0;
    logic        prev_rv   = 1'b0;
    logic [62:0] prev_pd   = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_pvld <= 1'b0;
            prev_rv   <= 1'b0;
        end else begin
            if (slv_req_pvld) begin
                chk("prdy_low_while_issuing", 64'(csb_req_prdy), 64'(0));
                if (prev_pvld && !prev_prdy)
                    chk("slv_req_pd_stable", 64'(slv_req_pd), 64'(prev_pd));
            end
            if (slv_req_pvld && slv_req_prdy) begin
                if (exp_slv_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_slv_req: got pd %0h expected none", slv_req_pd);
                end else begin
                    chk("slv_req_pd", 64'(slv_req_pd), 64'(exp_slv_q.pop_front()));
                end
            end
            if (csb_resp_valid) begin
                if (prev_rv) begin
                    checks++; errors++;
                    $display("FAIL resp_pulse_width: got 2+ cycles expected 1");
                end
                if (exp_resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_csb_resp: got pd %0h expected none", csb_resp_pd);
                end else begin
                    chk("csb_resp_pd", 64'(csb_resp_pd), 64'(exp_resp_q.pop_front()));
                    chk("csb_resp_latency", 64'(cyc - acc_cyc + 1), 64'(exp_lat_q.pop_front()));
                end
            end
            if (stale_resp) stale_seen++;
            prev_pvld <= slv_req_pvld;
            prev_prdy <= slv_req_prdy;
            prev_pd   <= slv_req_pd;
            prev_rv   <= csb_resp_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_prdy(input string name, input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (csb_req_prdy) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s: got prdy=0 after %0d cycles expected prdy=1", name, lim);
        end
    endtask

    task automatic accept(input logic [62:0] pd);
        wait_prdy("wait_req_prdy", 40);
        csb_req_pvld = 1'b1;
        csb_req_pd   = pd;
        tick();
        acc_cyc      = cyc;
        csb_req_pvld = 1'b0;
    endtask

    // Slave side: hold prdy low p cycles, then handshake.
    task automatic slave_take(input int p);
        for (int i = 0; i < 5 && !slv_req_pvld; i++) tick();
        repeat (p) tick();
        slv_req_prdy = 1'b1;
        tick();
        slv_req_prdy = 1'b0;
    endtask

    // d: response arrives d cycles after the slave handshake; 0 means the slave never answers.
    task automatic run_txn(input logic [62:0] pd, input int p, input int d, input logic [33:0] rpd);
        logic in_rng;
        logic rr;
        logic ok;
        in_rng = ((pd[21:0] & MASK) == BASE);
        rr     = !pd[54] || pd[55];
        if (in_rng) exp_slv_q.push_back(pd);
        if (rr) begin
            if (!in_rng) begin
                exp_resp_q.push_back({pd[54], 1'b1, 32'h0});
                exp_lat_q.push_back(1);
            end else if (d >= 1 && d <= TO) begin
                exp_resp_q.push_back(rpd);
                exp_lat_q.push_back(2 + p + d);
            end else begin
                exp_resp_q.push_back({pd[54], 1'b1, 32'h0});
                exp_lat_q.push_back(2 + p + TO);
                if (d > TO) exp_stale++;
            end
        end
        accept(pd);
        if (in_rng) begin
            slave_take(p);
            if (!rr) begin
                ok = csb_req_prdy;
                if (!ok) begin tick(); ok = csb_req_prdy; end
                chk("posted_write_prdy_back", 64'(ok), 64'(1));
            end else if (d >= 1) begin
                repeat (d - 1) tick();
                slv_resp_valid = 1'b1;
                slv_resp_pd    = rpd;
                tick();
                slv_resp_valid = 1'b0;
            end
        end
        wait_prdy("return_to_idle", 40);
        tick();
    endtask

    initial begin
        int s0;
        logic [62:0] pd;
        // Reset state
        tick();
        chk("reset_outputs", 64'({csb_req_prdy, slv_req_pvld, slv_req_pd, csb_resp_valid, csb_resp_pd, stale_resp}), 64'(0));
        rst = 1'b0;
        tick();

        // In-range read, slave answers two cycles after issue
        run_txn(mk(22'h000010, 32'h0, 1'b0, 1'b0, 7'h0), 0, 2, 34'h0_0001_0203);
        // In-range posted write
        run_txn(mk(22'h000004, 32'hDEADBEEF, 1'b1, 1'b0, 7'h1E), 0, 0, '0);
        // Out-of-range non-posted write
        run_txn(mk(22'h000400, 32'h12345678, 1'b1, 1'b1, 7'h0F), 0, 0, '0);
        // Out-of-range read and out-of-range posted write (dropped)
        run_txn(mk(22'h3FFFFF, 32'h0, 1'b0, 1'b0, 7'h0), 0, 0, '0);
        run_txn(mk(22'h000800, 32'h55AA55AA, 1'b1, 1'b0, 7'h0), 0, 0, '0);
        // Timeout, then late response 3 cycles after the error response
        s0 = stale_seen;
        run_txn(mk(22'h000020, 32'h0, 1'b0, 1'b0, 7'h0), 0, TO + 3, 34'h0_CAFE_F00D);
        repeat (2) tick();
        chk("stale_pulse_count", 64'(stale_seen - s0), 64'(1));
        // Response on the expiry cycle wins; slave ready held low 5 cycles
        run_txn(mk(22'h000030, 32'h0, 1'b0, 1'b0, 7'h0), 5, TO, 34'h0_8765_4321);
        // Non-posted write timing out reports bit33=1
        run_txn(mk(22'h000040, 32'h1, 1'b1, 1'b1, 7'h0), 1, 0, '0);

        // Reset in WAIT aborts the transaction with no response
        pd = mk(22'h000050, 32'h0, 1'b0, 1'b0, 7'h0);
        exp_slv_q.push_back(pd);
        accept(pd);
        slave_take(0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("reset_midflight_outputs", 64'({csb_req_prdy, slv_req_pvld, slv_req_pd, csb_resp_valid, csb_resp_pd, stale_resp}), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        run_txn(mk(22'h000060, 32'h0, 1'b0, 1'b0, 7'h0), 0, 1, 34'h0_0BAD_BEEF);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [21:0] a;
            a = ($urandom_range(0, 9) < 7) ? 22'($urandom_range(0, 1023))
                                           : (22'h000400 | 22'($urandom));
            run_txn(mk(a, 32'($urandom), 1'($urandom), 1'($urandom), 7'($urandom)),
                    $urandom_range(0, 3), $urandom_range(0, 11),
                    {2'($urandom_range(0, 3)), 32'($urandom)});
        end

        repeat (4) tick();
        chk("slv_req_queue_drained", 64'(exp_slv_q.size()), 64'(0));
        chk("resp_queue_drained", 64'(exp_resp_q.size()), 64'(0));
        chk("stale_total", 64'(stale_seen), 64'(exp_stale));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
